// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the CPU control sequencer: boot modes, instruction stages,
// and the UART start byte.
package stage_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_STALL = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_EXEC  = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_MEMORY   = 3'd3,
        ST_WRITEREG = 3'd4,
        ST_STOP     = 3'd5
    } stage_t;

    localparam logic [7:0] START_BYTE_DEF = 8'hAA;

endpackage

// File: rtl/stage_timer.sv
// Per-stage latency counter: clears on stage advance, increments while waiting,
// holds otherwise, and flags when it has reached the current stage latency.
module stage_timer #(
    parameter int unsigned LAT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt,
    output logic             hit
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + LAT_W'(1);
    end

    assign hit = (cnt == lat);

endmodule

// File: rtl/stage_sequencer.sv
// Boot-mode and instruction-stage sequencer: issues one-cycle latch strobes to the
// pipeline registers and owns the PC and retired-instruction count.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [7:0]  START_BYTE = START_BYTE_DEF,
    parameter int unsigned FETCH_LAT  = 0,
    parameter int unsigned DECODE_LAT = 0,
    parameter int unsigned EXEC_LAT   = 5,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned LAT_W      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        load_done,
    input  logic        ex_valid,
    input  logic        stop_inst,
    input  logic [31:0] npc,
    output logic [1:0]  mode,
    output logic [2:0]  stage,
    output logic        fd_latch,
    output logic        de_latch,
    output logic        em_latch,
    output logic        mw_latch,
    output logic        wb_commit,
    output logic        wb_clear,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted
);

    if (FETCH_LAT >= (1 << LAT_W) || DECODE_LAT >= (1 << LAT_W) ||
        EXEC_LAT  >= (1 << LAT_W) || MEM_LAT    >= (1 << LAT_W)) begin : g_lat_chk
        $error("stage_sequencer: a stage latency does not fit in LAT_W bits");
    end

    localparam logic [LAT_W-1:0] F_LAT = LAT_W'(FETCH_LAT);
    localparam logic [LAT_W-1:0] D_LAT = LAT_W'(DECODE_LAT);
    localparam logic [LAT_W-1:0] E_LAT = LAT_W'(EXEC_LAT);
    localparam logic [LAT_W-1:0] M_LAT = LAT_W'(MEM_LAT);

    mode_t            mode_q;
    stage_t           stage_q;
    stage_t           stage_nxt;
    logic             stop_q;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat;
    logic             hit;
    logic             clr;
    logic             inc;

    // WRITEREG is a fixed two-cycle commit/clear pair, so it compares against 1
    always_comb begin
        lat = '0;
        case (stage_q)
            ST_FETCH:    lat = F_LAT;
            ST_DECODE:   lat = D_LAT;
            ST_EXECUTE:  lat = E_LAT;
            ST_MEMORY:   lat = M_LAT;
            ST_WRITEREG: lat = LAT_W'(1);
            default:     lat = '0;
        endcase
    end

    stage_timer #(.LAT_W(LAT_W)) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (inc),
        .lat  (lat),
        .cnt  (cnt),
        .hit  (hit)
    );

    always_comb begin
        fd_latch  = 1'b0;
        de_latch  = 1'b0;
        em_latch  = 1'b0;
        mw_latch  = 1'b0;
        wb_commit = 1'b0;
        wb_clear  = 1'b0;
        clr       = 1'b0;
        inc       = 1'b0;
        if (mode_q == MODE_EXEC) begin
            case (stage_q)
                ST_FETCH:   if (hit) begin fd_latch = 1'b1; clr = 1'b1; end else inc = 1'b1;
                ST_DECODE:  if (hit) begin de_latch = 1'b1; clr = 1'b1; end else inc = 1'b1;
                ST_MEMORY:  if (hit) begin mw_latch = 1'b1; clr = 1'b1; end else inc = 1'b1;
                // Execute waits at its latency for ex_valid without wrapping the counter
                ST_EXECUTE: begin
                    if (!hit)
                        inc = 1'b1;
                    else if (ex_valid) begin
                        em_latch = 1'b1;
                        clr      = 1'b1;
                    end
                end
                ST_WRITEREG: begin
                    if (hit) begin
                        wb_clear = 1'b1;
                        clr      = 1'b1;
                    end else begin
                        wb_commit = 1'b1;
                        inc       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stage_nxt = stage_q;
        case (stage_q)
            ST_FETCH:    stage_nxt = ST_DECODE;
            ST_DECODE:   stage_nxt = ST_EXECUTE;
            ST_EXECUTE:  stage_nxt = ST_MEMORY;
            ST_MEMORY:   stage_nxt = ST_WRITEREG;
            ST_WRITEREG: stage_nxt = stop_q ? ST_STOP : ST_FETCH;
            default:     stage_nxt = stage_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= MODE_STALL;
            stage_q <= ST_FETCH;
            stop_q  <= 1'b0;
            pc      <= '0;
            retired <= '0;
        end else begin
            case (mode_q)
                MODE_STALL: if (rx_ready && rx_data == START_BYTE) mode_q <= MODE_LOAD;
                MODE_LOAD:  if (load_done) mode_q <= MODE_EXEC;
                default:    ;
            endcase
            if (clr)
                stage_q <= stage_nxt;
            if (de_latch)
                stop_q <= stop_inst;
            if (mw_latch)
                pc <= npc;
            if (wb_clear)
                retired <= retired + 32'd1;
        end
    end

    assign mode   = mode_q;
    assign stage  = stage_q;
    assign halted = (stage_q == ST_STOP);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: table-driven instruction walk plus hand-written
// boot, ex_valid stall, STOP, async reset and retire-wrap sequences.
module tb_stage_sequencer;

    logic        clk;
    logic        rstn;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        load_done;
    logic        ex_valid;
    logic        stop_inst;
    logic [31:0] npc;
    logic [1:0]  mode;
    logic [2:0]  stage;
    logic        fd_latch, de_latch, em_latch, mw_latch, wb_commit, wb_clear;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    stage_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .load_done (load_done),
        .ex_valid  (ex_valid),
        .stop_inst (stop_inst),
        .npc       (npc),
        .mode      (mode),
        .stage     (stage),
        .fd_latch  (fd_latch),
        .de_latch  (de_latch),
        .em_latch  (em_latch),
        .mw_latch  (mw_latch),
        .wb_commit (wb_commit),
        .wb_clear  (wb_clear),
        .pc        (pc),
        .retired   (retired),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] strb;
    assign strb = {fd_latch, de_latch, em_latch, mw_latch, wb_commit, wb_clear};

    typedef struct packed {
        logic       ex_valid;
        logic [2:0] stage;
        logic [5:0] strb;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic boot();
        rx_ready = 1'b1;
        rx_data  = 8'hAA;
        step();
        rx_ready  = 1'b0;
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("boot_mode_exec", 32'(mode), 32'd2);
    endtask

    // One full default-latency instruction, checked cycle by cycle against the table
    task automatic run_tab(input string tag, input logic [31:0] n, input logic stp);
        npc       = n;
        stop_inst = stp;
        for (int i = 0; i < 12; i++) begin
            ex_valid = vec[i].ex_valid;
            @(negedge clk);
            chk($sformatf("%s_strb_c%0d", tag, i), 32'(strb), 32'(vec[i].strb));
            chk($sformatf("%s_stage_c%0d", tag, i), 32'(stage), 32'(vec[i].stage));
            step();
        end
        stop_inst = 1'b0;
    endtask

    initial begin
        int bad;
        logic [5:0] tail [4];

        vec[0]  = '{1'b1, 3'd0, 6'b100000};
        vec[1]  = '{1'b1, 3'd1, 6'b010000};
        vec[2]  = '{1'b1, 3'd2, 6'b000000};
        vec[3]  = '{1'b1, 3'd2, 6'b000000};
        vec[4]  = '{1'b1, 3'd2, 6'b000000};
        vec[5]  = '{1'b1, 3'd2, 6'b000000};
        vec[6]  = '{1'b1, 3'd2, 6'b000000};
        vec[7]  = '{1'b1, 3'd2, 6'b001000};
        vec[8]  = '{1'b1, 3'd3, 6'b000000};
        vec[9]  = '{1'b1, 3'd3, 6'b000100};
        vec[10] = '{1'b1, 3'd4, 6'b000010};
        vec[11] = '{1'b1, 3'd4, 6'b000001};
        tail[0] = 6'b000000;
        tail[1] = 6'b000100;
        tail[2] = 6'b000010;
        tail[3] = 6'b000001;

        rstn = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; load_done = 1'b0;
        ex_valid = 1'b0; stop_inst = 1'b0; npc = 32'h0;

        // Reset state
        #7;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_strb", 32'(strb), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #5 rstn = 1'b1;
        step();

        // Boot: non-start byte ignored, start byte enters LOAD one edge later
        rx_ready = 1'b1; rx_data = 8'h55;
        step();
        rx_ready = 1'b0;
        chk("stall_after_55", 32'(mode), 32'd0);
        step();
        chk("stall_idle", 32'(mode), 32'd0);
        rx_ready = 1'b1; rx_data = 8'hAA;
        @(negedge clk);
        chk("stall_before_edge", 32'(mode), 32'd0);
        step();
        rx_ready = 1'b0;
        chk("load_after_aa", 32'(mode), 32'd1);
        step();
        chk("load_waits", 32'(mode), 32'd1);
        chk("load_no_strb", 32'(strb), 32'd0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("exec_entry", 32'(mode), 32'd2);

        // First instruction
        run_tab("i1", 32'h4, 1'b0);
        chk("i1_pc", pc, 32'h4);
        chk("i1_retired", retired, 32'd1);
        chk("i1_stage", 32'(stage), 32'd0);

        // ex_valid held low at EXECUTE
        npc = 32'h8; ex_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("i2_pre_c%0d", i), 32'(strb), 32'(vec[i].strb & 6'b110000));
            step();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("i2_hold_c%0d", i), {26'd0, strb, 3'd0} | 32'(stage), 32'd2);
            step();
        end
        chk("i2_cnt_held", 32'(dut.cnt), 32'd5);
        ex_valid = 1'b1;
        @(negedge clk);
        chk("i2_em_same_cycle", 32'(strb), 32'b001000);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("i2_tail_c%0d", i), 32'(strb), 32'(tail[i]));
            step();
        end
        chk("i2_pc", pc, 32'h8);
        chk("i2_retired", retired, 32'd2);

        // Retire counter wrap
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        run_tab("i3", 32'hC, 1'b0);
        chk("wrap_retired", retired, 32'd0);
        chk("wrap_pc", pc, 32'hC);

        // STOP instruction completes, then the sequencer goes silent
        run_tab("i4", 32'h10, 1'b1);
        chk("stop_retired", retired, 32'd1);
        chk("stop_pc", pc, 32'h10);
        chk("stop_stage", 32'(stage), 32'd5);
        chk("stop_halted", 32'(halted), 32'd1);
        bad = 0;
        rx_data = 8'hAA;
        for (int i = 0; i < 100; i++) begin
            load_done = i[0];
            rx_ready  = i[1];
            ex_valid  = i[2];
            npc       = 32'(i);
            @(negedge clk);
            if (strb != 6'd0 || halted !== 1'b1) bad++;
            step();
        end
        load_done = 1'b0; rx_ready = 1'b0; ex_valid = 1'b0;
        chk("stop_silent_cycles", 32'(bad), 32'd0);
        chk("stop_pc_frozen", pc, 32'h10);
        chk("stop_retired_frozen", retired, 32'd1);

        // Reset is the only exit from STOP
        #2 rstn = 1'b0;
        #1;
        chk("stop_exit_halted", 32'(halted), 32'd0);
        chk("stop_exit_stage", 32'(stage), 32'd0);
        #2 rstn = 1'b1;
        step();
        boot();
        run_tab("i5", 32'h20, 1'b0);
        chk("i5_pc", pc, 32'h20);

        // Async reset mid-EXECUTE with cnt==3
        ex_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_exec_stage", 32'(stage), 32'd2);
        chk("mid_exec_cnt", 32'(dut.cnt), 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("async_mode", 32'(mode), 32'd0);
        chk("async_stage", 32'(stage), 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_retired", retired, 32'd0);
        chk("async_strb", 32'(strb), 32'd0);
        chk("async_cnt", 32'(dut.cnt), 32'd0);
        #2 rstn = 1'b1;
        step();
        chk("post_reset_mode", 32'(mode), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
